// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter: fixed-priority or rotating round-robin, with grant lock
// until release and optional hold-time preemption of a long-running owner.
module priority_arbiter_rr #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt
);

  localparam int          HC_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam int unsigned NU       = N;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [HC_W-1:0]   hold_cnt, hc_nxt;
  logic [N-1:0]      grant_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              valid_nxt, pre_nxt;

  logic [N-1:0]      cand;
  logic              owner_on, found;
  logic              lo_found, hi_found;
  logic [IDX_W-1:0]  lo_idx, hi_idx, win_idx;
  int unsigned       start;
  logic              take, pre, clr;

  // The current owner is masked out, so a release or preempt never re-picks it.
  assign cand     = req & ~grant;
  assign owner_on = |(req & grant);

  // Descending order from start with wrap: indices <= start beat indices > start,
  // and within each half the highest set index wins.
  always_comb begin
    start    = mode ? int'(ptr) : NU - 1;
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (cand[i]) begin
        if (i <= start) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end else begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    found   = lo_found | hi_found;
    win_idx = lo_found ? lo_idx : hi_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= IDX_W'(N - 1);
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hc_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      preempt     <= pre_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pre       = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          take      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!owner_on) begin
          if (found) begin
            take = 1'b1;
          end else begin
            clr       = 1'b1;
            state_nxt = IDLE;
          end
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIM && found) begin
          take = 1'b1;
          pre  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    valid_nxt = grant_valid;
    pre_nxt   = pre;
    ptr_nxt   = ptr;
    hc_nxt    = hold_cnt;
    if (take) begin
      grant_nxt = {{(N-1){1'b0}}, 1'b1} << win_idx;
      idx_nxt   = win_idx;
      valid_nxt = 1'b1;
      ptr_nxt   = (win_idx == '0) ? IDX_W'(N - 1) : win_idx - 1'b1;
      hc_nxt    = '0;
    end else if (clr) begin
      grant_nxt = '0;
      idx_nxt   = '0;
      valid_nxt = 1'b0;
      hc_nxt    = '0;
    end else if (state == GRANT && hold_cnt != HOLD_LIM) begin
      hc_nxt = hold_cnt + 1'b1;
    end
  end

endmodule
